// File: rtl/ahb_to_apb_bridge_pkg.sv
// ahb_apb_pkg: shared AHB transfer/response encodings and bridge FSM states
package ahb_apb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic       HRESP_OKAY    = 1'b0;
  typedef enum logic [2:0] {
    IDLE,
    W_WAIT,
    W_SETUP,
    W_ENABLE,
    R_SETUP,
    R_ENABLE
  } bridge_state_t;
endpackage

// File: rtl/ahb_to_apb_bridge_if.sv
// reg_if: AHB-Lite slave side and APB master side of the bridge, clocked by hclk
interface reg_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic hclk
);
  logic                  hselapb;
  logic                  hwrite;
  logic [ADDR_WIDTH-1:0] haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic [1:0]            htrans;
  logic                  hresp;
  logic                  hready;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  modport master (
    input  hclk, hresp, hready, hrdata, psel, penable, pwrite, paddr, pwdata,
    output hselapb, hwrite, haddr, hwdata, prdata, htrans
  );
  modport slave (
    input  hclk, hselapb, hwrite, haddr, hwdata, prdata, htrans,
    output hresp, hready, hrdata, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/ahb_to_apb_bridge.sv
// ahb_to_apb_bridge: non-pipelined AHB-Lite slave that turns each accepted transfer
// into one zero-wait APB SETUP/ENABLE access, stalling AHB via hready meanwhile
module ahb_to_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic  hclk,
  input logic  hresetn,
  reg_if.slave bus
);
  bridge_state_t         state, next;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] hrdata_q;
  logic                  pwrite_q;
  logic                  valid;
  // an X select evaluates false in the if tests below, so the FSM stays in IDLE
  assign valid = bus.hselapb & (bus.htrans == HTRANS_NONSEQ || bus.htrans == HTRANS_SEQ);
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= IDLE;
    else          state <= next;
  end
  always_comb begin
    next = IDLE;
    case (state)
      IDLE:    if (valid) next = bus.hwrite ? W_WAIT : R_SETUP;
      W_WAIT:  next = W_SETUP;
      W_SETUP: next = W_ENABLE;
      R_SETUP: next = R_ENABLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    bus.hready  = state == IDLE;
    bus.psel    = state != IDLE && state != W_WAIT;
    bus.penable = state == W_ENABLE || state == R_ENABLE;
    bus.hresp   = HRESP_OKAY;
    bus.pwrite  = pwrite_q;
    bus.paddr   = paddr_q;
    bus.pwdata  = pwdata_q;
    bus.hrdata  = hrdata_q;
  end
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      if (state == IDLE && valid) begin
        paddr_q  <= bus.haddr;
        pwrite_q <= bus.hwrite;
      end
      if (state == W_WAIT) pwdata_q <= bus.hwdata;
      if (state == R_ENABLE) hrdata_q <= bus.prdata;
    end
  end
endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// tb_ahb_to_apb_bridge: directed AHB write/read/ignore/reset vectors with hand-computed expectations
module tb_ahb_to_apb_bridge;
  import ahb_apb_pkg::*;
  logic hclk = 1'b0;
  logic hresetn;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_hrdata = '0;
  always #5 hclk = ~hclk;
  reg_if bus (hclk);
  ahb_to_apb_bridge dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle_bus();
    bus.hselapb = 1'b0;
    bus.htrans  = HTRANS_IDLE;
    bus.haddr   = 32'hdead_beef;
  endtask
  // entered and left just after a falling edge with the bridge in IDLE
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] trans);
    check("w_accept_rdy", bus.hready, 1);
    bus.hselapb = 1'b1;
    bus.htrans  = trans;
    bus.hwrite  = 1'b1;
    bus.haddr   = addr;
    @(negedge hclk);
    idle_bus();
    bus.hwdata = data;
    check("w_wait_rdy", bus.hready, 0);
    check("w_wait_psel", bus.psel, 0);
    @(negedge hclk);
    bus.hwdata = ~data;
    check("w_setup_psel", bus.psel, 1);
    check("w_setup_pen", bus.penable, 0);
    check("w_setup_pwrite", bus.pwrite, 1);
    check("w_setup_paddr", bus.paddr, addr);
    check("w_setup_pwdata", bus.pwdata, data);
    check("w_setup_rdy", bus.hready, 0);
    @(negedge hclk);
    check("w_en_psel", bus.psel, 1);
    check("w_en_pen", bus.penable, 1);
    check("w_en_paddr", bus.paddr, addr);
    check("w_en_pwdata", bus.pwdata, data);
    check("w_en_rdy", bus.hready, 0);
    @(negedge hclk);
    check("w_done_rdy", bus.hready, 1);
    check("w_done_psel", bus.psel, 0);
    check("w_done_pen", bus.penable, 0);
    check("w_done_paddr", bus.paddr, addr);
    check("w_done_pwdata", bus.pwdata, data);
  endtask
  task automatic do_read(input logic [31:0] addr, input logic [31:0] rd, input logic [1:0] trans);
    check("r_accept_rdy", bus.hready, 1);
    bus.hselapb = 1'b1;
    bus.htrans  = trans;
    bus.hwrite  = 1'b0;
    bus.haddr   = addr;
    bus.prdata  = ~rd;
    @(negedge hclk);
    idle_bus();
    bus.prdata = rd;
    check("r_setup_psel", bus.psel, 1);
    check("r_setup_pen", bus.penable, 0);
    check("r_setup_pwrite", bus.pwrite, 0);
    check("r_setup_paddr", bus.paddr, addr);
    check("r_setup_rdy", bus.hready, 0);
    @(negedge hclk);
    check("r_en_psel", bus.psel, 1);
    check("r_en_pen", bus.penable, 1);
    check("r_en_rdy", bus.hready, 0);
    check("r_en_hrdata_old", bus.hrdata, exp_hrdata);
    @(negedge hclk);
    bus.prdata = $urandom;
    exp_hrdata = rd;
    check("r_done_rdy", bus.hready, 1);
    check("r_done_psel", bus.psel, 0);
    check("r_done_hrdata", bus.hrdata, rd);
    check("r_done_paddr", bus.paddr, addr);
  endtask
  logic [2:0] ign_vec [4] = '{3'b100, 3'b101, 3'b010, 3'b011};
  initial begin
    hresetn     = 1'b0;
    bus.hselapb = 1'($urandom);
    bus.htrans  = 2'($urandom);
    bus.hwrite  = 1'($urandom);
    bus.haddr   = $urandom;
    bus.hwdata  = $urandom;
    bus.prdata  = $urandom;
    #3;
    check("rst_rdy", bus.hready, 1);
    check("rst_psel", bus.psel, 0);
    check("rst_pen", bus.penable, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_hrdata", bus.hrdata, 0);
    check("rst_hresp", bus.hresp, 0);
    check("rst_pwdata", bus.pwdata, 0);
    check("rst_pwrite", bus.pwrite, 0);
    idle_bus();
    @(negedge hclk);
    hresetn = 1'b1;
    do_write(32'd8, 32'd34, HTRANS_NONSEQ);
    // reset asserted during W_SETUP must drop psel without a clock edge
    bus.hselapb = 1'b1;
    bus.htrans  = HTRANS_NONSEQ;
    bus.hwrite  = 1'b1;
    bus.haddr   = 32'd16;
    @(negedge hclk);
    idle_bus();
    bus.hwdata = 32'd55;
    @(negedge hclk);
    check("wsetup_psel_pre", bus.psel, 1);
    hresetn = 1'b0;
    #1;
    check("wrst_psel", bus.psel, 0);
    check("wrst_pen", bus.penable, 0);
    check("wrst_rdy", bus.hready, 1);
    check("wrst_paddr", bus.paddr, 0);
    @(negedge hclk);
    hresetn = 1'b1;
    // reset during R_ENABLE: transfer lost, hrdata stays 0
    bus.hselapb = 1'b1;
    bus.htrans  = HTRANS_NONSEQ;
    bus.hwrite  = 1'b0;
    bus.haddr   = 32'd8;
    @(negedge hclk);
    idle_bus();
    bus.prdata = 32'd77;
    @(negedge hclk);
    check("renable_pen_pre", bus.penable, 1);
    hresetn = 1'b0;
    #1;
    check("rrst_psel", bus.psel, 0);
    check("rrst_pen", bus.penable, 0);
    check("rrst_hrdata", bus.hrdata, 0);
    @(negedge hclk);
    check("rrst_hrdata_hold", bus.hrdata, 0);
    hresetn = 1'b1;
    exp_hrdata = '0;
    do_read(32'd8, 32'd30, HTRANS_NONSEQ);
    for (int i = 0; i < 4; i++) begin
      bus.hselapb = ign_vec[i][2];
      bus.htrans  = ign_vec[i][1:0];
      bus.hwrite  = 1'($urandom);
      bus.haddr   = 32'h100 + i;
      @(negedge hclk);
      check("ign_psel", bus.psel, 0);
      check("ign_rdy", bus.hready, 1);
      @(negedge hclk);
      check("ign_psel2", bus.psel, 0);
      check("ign_paddr", bus.paddr, 8);
    end
    idle_bus();
    do_write(32'd4, 32'h1234_5678, HTRANS_SEQ);
    do_read(32'd12, 32'hcafe_f00d, HTRANS_NONSEQ);
    do_read(32'd20, 32'h0bad_0001, HTRANS_SEQ);
    check("final_hrdata", bus.hrdata, 32'h0bad_0001);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_to_apb_bridge.md
Name: ahb_to_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge that sits between the AHB system bus and the APB peripheral segment.
- Converts each selected AHB single transfer into a two-phase APB access (SETUP, then ENABLE).
- Stalls AHB via hready while the APB access is in progress.
- Non-pipelined: at most one outstanding transfer; responses are always OKAY.

Parameters:
- ADDR_WIDTH, 32, width of haddr/paddr
- DATA_WIDTH, 32, width of hwdata/hrdata/pwdata/prdata

Ports:
- hclk  in  1  bus clock; all state changes on the rising edge
- hresetn  in  1  asynchronous active-low reset
- hselapb  in  1  AHB slave select for the APB region
- hwrite  in  1  AHB direction; 1 = write
- haddr  in  ADDR_WIDTH  AHB address (address phase)
- hwdata  in  DATA_WIDTH  AHB write data (data phase)
- prdata  in  DATA_WIDTH  APB read data
- htrans  in  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hresp  out  1  AHB response; constant 0 (OKAY)
- hready  out  1  AHB ready; 1 = bridge can accept or complete a transfer
- hrdata  out  DATA_WIDTH  AHB read data, registered
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_WIDTH  APB address, registered
- pwdata  out  DATA_WIDTH  APB write data, registered

Behaviour:
- Clocking and reset: one clock, hclk. Reset is asynchronous and active-low on hresetn.
- Reset values: state = IDLE, hready = 1, hresp = 0, and psel, penable, pwrite, paddr, pwdata, hrdata all 0.
- Reset mid-operation: the FSM aborts to IDLE immediately and psel/penable drop with no clock edge needed. The aborted transfer is lost.
- valid = hselapb & htrans[1]. NONSEQ and SEQ start a transfer; IDLE and BUSY are ignored.
- States and transitions:
  - IDLE: hready=1, psel=0, penable=0.
    - If valid: latch haddr into paddr and hwrite into pwrite.
    - Then go to W_WAIT if hwrite=1, else to R_SETUP.
    - Otherwise stay in IDLE.
  - W_WAIT: hready=0. Latch hwdata into pwdata at the edge leaving the state. Next state W_SETUP.
  - W_SETUP: psel=1, penable=0, pwrite=1. Next state W_ENABLE.
  - W_ENABLE: psel=1, penable=1. Next state IDLE.
  - R_SETUP: psel=1, penable=0, pwrite=0, hready=0. Next state R_ENABLE.
  - R_ENABLE: psel=1, penable=1, hready=0. Latch prdata into hrdata at the edge leaving the state. Next state IDLE.
- hready is 0 in every state except IDLE.
- Latency from the accept edge:
  - Read: 3 cycles; hready returns to 1 with hrdata valid in the first IDLE cycle.
  - Write: 4 cycles.
- paddr, pwdata and pwrite hold their values through SETUP and ENABLE. They also hold in IDLE until the next accepted transfer.
- hrdata holds its last read value until the next read completes.
- Accepting a new transfer in IDLE on the same cycle a previous transfer completed is legal; back-to-back transfers are allowed.
- APB peripherals are zero-wait-state; there is no pready input.
- Only the low ADDR_WIDTH bits of haddr are forwarded. No address decoding or error responses.
- X or undriven hselapb is treated as not selected: the FSM must not leave IDLE.

Decomposition:
- Shared package ahb_apb_pkg:
  - HTRANS constants (HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ).
  - HRESP_OKAY.
  - bridge_state_t enum: IDLE, W_WAIT, W_SETUP, W_ENABLE, R_SETUP, R_ENABLE.
- Single module; no sub-module is needed. The FSM and datapath registers stay in one block.
- Verification uses a reg_if interface bundling all non-clock signals, clocked by hclk.

Test Plan:
- Reset: hresetn=0 with random inputs -> hready=1, psel=0, penable=0, paddr=0, hrdata=0, hresp=0. Assert reset in the middle of W_SETUP -> psel falls asynchronously.
- Write: hselapb=1, htrans=10, hwrite=1, haddr=8, then hwdata=34 -> W_WAIT, W_SETUP (psel=1, paddr=8, pwdata=34, pwrite=1), W_ENABLE (penable=1), IDLE with hready=1. hready is low for exactly 3 cycles.
- Read: htrans=10, hwrite=0, haddr=8, prdata=30 -> R_SETUP, R_ENABLE, then IDLE with hrdata=30 and hready=1, after hready was low for 2 cycles.
- Ignored transfers: htrans=00 or 01, or hselapb=0 -> psel stays 0 and hready stays 1.
- Back-to-back: a SEQ (htrans=11) write followed immediately by a read at haddr=12 -> the second transfer is accepted in the IDLE cycle after the first completes, with correct paddr values for each.
- Reset mid-read: hresetn=0 during R_ENABLE -> psel=0, penable=0 and hrdata keeps its prior value of 0. After release, a fresh read completes normally.
